// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit stage.
//   - uart_state_e  : transmitter FSM state encoding
//   - UART_DATA_BITS: payload bits per frame
//   - UART_IDLE_LEVEL: line level when no frame is being sent
//   - tx_level()    : serial line level for a given FSM state
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Line level driven while the FSM sits in a state; data_bit is the
    // current LSB of the shift register and only matters in DATA.
    function automatic logic tx_level(input uart_state_e st, input logic data_bit);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_bit;
            default:  lvl = UART_IDLE_LEVEL;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sync_fifo_8.sv
// Single-clock byte FIFO.
//   clk, resetn : clock and asynchronous active-low reset
//   push, din   : write request and data (ignored when full without pop)
//   pop, dout   : read request; dout shows the head entry combinationally
//   count       : registered occupancy
//   full, empty : occupancy flags derived from count
module sync_fifo_8 #(
    parameter  int FIFO_DEPTH = 16,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Console transmit stage: buffers strobed bytes and sends them as 8N1 frames.
//   clk, resetn : clock and asynchronous active-low reset
//   in_byte     : byte from the system output register
//   in_valid    : one-cycle strobe qualifying in_byte
//   ovf_clr     : synchronous clear of the sticky overflow flag
//   tx          : registered serial output, idle high
//   busy        : registered; high while a frame is in flight or bytes wait
//   fifo_count  : FIFO occupancy
//   overflow    : sticky; a byte arrived while the FIFO was full
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLK_DIV    = 434,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             ovf_clr,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int               BAUD_W      = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_state_e       state_r;
    uart_state_e       state_nxt_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_nxt_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_nxt_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_nxt_s;
    logic              tx_r;
    logic              busy_r;
    logic              overflow_r;

    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              bit_end_s;
    logic [7:0]        fifo_dout_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    sync_fifo_8 #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .pop    (pop_s),
        .din    (in_byte),
        .dout   (fifo_dout_s),
        .count  (fifo_count_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    assign bit_end_s = (baud_r == {BAUD_W{1'b0}});
    // The source cannot be stalled: a byte that finds no room is lost and flagged.
    assign push_s    = in_valid & (~fifo_full_s | pop_s);
    assign drop_s    = in_valid & fifo_full_s & ~pop_s;

    // Next-state logic for the frame sequencer, baud counter and shift register.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_dout_s;
                    baud_nxt_s  = BAUD_RELOAD;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    bit_idx_nxt_s = 3'd0;
                    baud_nxt_s    = BAUD_RELOAD;
                    state_nxt_s   = ST_DATA;
                end else begin
                    baud_nxt_s = baud_r - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    baud_nxt_s  = BAUD_RELOAD;
                    if (bit_idx_r == LAST_BIT) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    // Chain straight into the next start bit so queued frames are gapless.
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = fifo_dout_s;
                        baud_nxt_s  = BAUD_RELOAD;
                        state_nxt_s = ST_START;
                    end else begin
                        baud_nxt_s  = {BAUD_W{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r - BAUD_W'(1);
                end
            end
            default: begin
                baud_nxt_s    = {BAUD_W{1'b0}};
                bit_idx_nxt_s = 3'd0;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Line and status outputs, registered from the current sequencer state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_r   <= UART_IDLE_LEVEL;
            busy_r <= 1'b0;
        end else begin
            tx_r   <= tx_level(state_r, shift_r[0]);
            busy_r <= (state_r != ST_IDLE) | ~fifo_empty_s;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_count = fifo_count_s;
    assign overflow   = overflow_r;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial console stage directly downstream of the CPU system's byte-output port at 0x1000_0000.
- Consumes the registered byte plus its one-cycle enable strobe and buffers bytes in a small FIFO.
- Shifts bytes out as 8N1 UART frames on a single tx pin so firmware prints reach a host terminal.
- The source has no backpressure, so the block buffers bursts and flags drops instead of stalling.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (>=2); default gives 115200 baud at 50 MHz.
- FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the fifo_count port; derived, not overridden.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- in_byte  in  8  byte from the system output register
- in_valid  in  1  one-cycle strobe; in_byte is valid in that cycle
- ovf_clr  in  1  synchronous clear of the overflow flag
- tx  out  1  UART serial output, idle high
- busy  out  1  high while a frame is in flight or the FIFO is non-empty
- fifo_count  out  CNT_W  current FIFO occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

Interface (already decided):
- One clock, clk.
- Reset resetn is asynchronous and active-low.

Behaviour:
- Reset (resetn=0, asynchronous): tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0. FIFO pointers cleared; FIFO contents are don't-care.
- FIFO write:
  - Occurs on a clk edge with in_valid=1 and (fifo_count<FIFO_DEPTH or pop in the same cycle).
  - in_valid=1 when full with no same-cycle pop: byte dropped, overflow<=1.
- Overflow flag:
  - ovf_clr=1 clears overflow.
  - If a drop occurs in the same cycle as ovf_clr, set wins.
- FIFO read (pop) occurs in two cases:
  - FSM in IDLE and FIFO non-empty.
  - Last cycle of STOP and FIFO non-empty.
- Simultaneous push and pop: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: tx=1. When fifo_count!=0: pop into the shift register, baud counter<=CLK_DIV-1, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0], LSB first, each bit held CLK_DIV cycles. Shift right after each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On the final cycle, pop and go to START if the FIFO is non-empty, else go to IDLE. There is no idle gap between queued frames.
- Baud counter:
  - Loads CLK_DIV-1 on entry to each bit.
  - Decrements each clk; the bit ends when it reads 0.
  - Width is $clog2(CLK_DIV).
- tx is a registered output (no combinational path from the FSM). Frame length is exactly 10*CLK_DIV cycles.
- Latency: in_valid at edge N with FSM idle and FIFO empty:
  - fifo_count=1 after edge N.
  - Pop at edge N+1.
  - tx=0 after edge N+2 (two cycles).
- busy = (FSM!=IDLE) or (fifo_count!=0), registered-equivalent with no glitches. Deasserts in the cycle the FSM returns to IDLE with the FIFO empty.
- in_valid is sampled only at clk edges; any value on in_byte outside a strobe is ignored.
- Reset mid-frame: tx goes to 1 immediately; the partial frame and queued bytes are discarded.

Decomposition:
- Shared package/include uart_pkg:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - UART_DATA_BITS=8.
  - Idle line level constant (1).
- One natural sub-module, sync_fifo_8:
  - Parameterised by FIFO_DEPTH; single clock; async active-low reset.
  - push/pop/din/dout/count/full/empty.
  - Registered count; dout is combinational from the read pointer.
- uart_tx_fifo instantiates sync_fifo_8 and holds the FSM, baud counter and shift register.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4 unless stated):
1. Assert resetn=0 mid-simulation, no clk edge -> tx=1, busy=0, fifo_count=0, overflow=0 immediately; outputs held while reset is low.
2. Single strobe in_byte=8'hA5 at edge N -> tx=0 over cycles N+2..N+5; data bits 1,0,1,0,0,1,0,1 each held 4 cycles; stop=1 for 4 cycles; busy falls at N+42; overflow stays 0.
3. Six strobes on consecutive edges (0x01..0x06) -> 0x01 popped early, 0x02..0x05 accepted, 0x06 dropped; overflow=1; five contiguous frames totalling 200 cycles with no idle gap; received bytes are 01,02,03,04,05.
4. With overflow=1, pulse ovf_clr -> overflow=0 next edge. Repeat with ovf_clr coinciding with a drop -> overflow stays 1.
5. FIFO full, strobe in_byte=8'h7E on the STOP final cycle (pop edge) -> byte accepted, fifo_count unchanged at 4, overflow=0, 0x7E transmitted last.
6. Deassert resetn during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 asynchronously, fifo_count=0; after release, no frame is emitted and busy=0.
